// File: rtl/wn_pdcchrx_modrem_ctrl.sv
// Purpose : job sequencer in front of modulation removal; gates DMRS/data streams per CORESET job, regenerates per-symbol tlast, tracks estimate completion.
// Latency : zero-cycle combinational forwarding in RUN; cfg accept -> first beat 1 cycle; last estimate tlast (DRAIN) -> done 1 cycle.
// Backpress: upstream tready mirrors engine tready while beats remain in the job; held 0 outside RUN, so surplus beats stay upstream.
//
// Ports:
//   clk, rstn                        clock, async active-low reset
//   cfg_in_*                         job config: [8:0] n_rb, [10:9] n_symb
//   up_dmrs_* / up_data_*            upstream DMRS sequence and received DMRS REs
//   dmrs_out_* / data_out_*          towards engine dmrs_in / data_in
//   estm_tvalid/tready/tlast         snoop of engine estimate output handshake
//   busy, done, err                  job active, end-of-job pulse, sticky error
//
// Optional build macro WN_PDCCHRX_MODREM_CTRL_ERRCHK_EN: compare up_data_tlast with
// the regenerated tlast on every data beat and flag a mismatch in err.
module wn_pdcchrx_modrem_ctrl #(
    parameter int nRX    = 2,
    parameter int MAX_RB = 275
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [15:0]        cfg_in_tdata,
    input  logic               cfg_in_tvalid,
    output logic               cfg_in_tready,
    input  logic [7:0]         up_dmrs_tdata,
    input  logic               up_dmrs_tvalid,
    output logic               up_dmrs_tready,
    input  logic [nRX*32-1:0]  up_data_tdata,
    input  logic               up_data_tvalid,
    input  logic               up_data_tlast,
    output logic               up_data_tready,
    output logic [7:0]         dmrs_out_tdata,
    output logic               dmrs_out_tvalid,
    input  logic               dmrs_out_tready,
    output logic [nRX*32-1:0]  data_out_tdata,
    output logic               data_out_tvalid,
    output logic               data_out_tlast,
    input  logic               data_out_tready,
    input  logic               estm_tvalid,
    input  logic               estm_tready,
    input  logic               estm_tlast,
    output logic               busy,
    output logic               done,
    output logic               err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [8:0] MAX_RB_L = 9'(MAX_RB);

    state_t      state_q, state_d;
    logic [1:0]  n_symb_q, n_symb_d;
    logic [9:0]  re_per_sym_q, re_per_sym_d;
    logic [11:0] total_q, total_d;
    logic [11:0] dmrs_cnt_q, dmrs_cnt_d;
    logic [11:0] data_cnt_q, data_cnt_d;
    logic [9:0]  sym_re_cnt_q, sym_re_cnt_d;
    logic [1:0]  out_cnt_q, out_cnt_d;
    logic        err_q, err_d;

    // Config decode; only meaningful (and only latched) when cfg_ok.
    logic [8:0]  cfg_n_rb;
    logic [1:0]  cfg_n_symb;
    logic        cfg_ok;
    logic [9:0]  cfg_re;
    logic [11:0] cfg_total;
    logic        cfg_rsvd_unused;

    assign cfg_n_rb        = cfg_in_tdata[8:0];
    assign cfg_n_symb      = cfg_in_tdata[10:9];
    assign cfg_rsvd_unused = ^cfg_in_tdata[15:11];
    assign cfg_ok          = (cfg_n_rb != 9'd0) && (cfg_n_rb <= MAX_RB_L) && (cfg_n_symb != 2'd0);
    assign cfg_re          = {cfg_n_rb, 1'b0} + {1'b0, cfg_n_rb};
    assign cfg_total       = {2'b00, cfg_re} * {10'd0, cfg_n_symb};

    // Stream gating: a stream is open only in RUN and only while beats remain.
    logic in_run, dmrs_room, data_room, dmrs_hs, data_hs, estm_last_hs;
    logic tlast_mismatch;

    assign in_run          = (state_q == S_RUN);
    assign dmrs_room       = in_run && (dmrs_cnt_q < total_q);
    assign data_room       = in_run && (data_cnt_q < total_q);

    assign dmrs_out_tdata  = up_dmrs_tdata;
    assign dmrs_out_tvalid = up_dmrs_tvalid && dmrs_room;
    assign up_dmrs_tready  = dmrs_out_tready && dmrs_room;

    assign data_out_tdata  = up_data_tdata;
    assign data_out_tvalid = up_data_tvalid && data_room;
    assign up_data_tready  = data_out_tready && data_room;
    assign data_out_tlast  = data_room && (sym_re_cnt_q == (re_per_sym_q - 10'd1));

    assign dmrs_hs         = dmrs_out_tvalid && dmrs_out_tready;
    assign data_hs         = data_out_tvalid && data_out_tready;
    assign estm_last_hs    = estm_tvalid && estm_tready && estm_tlast &&
                             ((state_q == S_RUN) || (state_q == S_DRAIN));

`ifdef WN_PDCCHRX_MODREM_CTRL_ERRCHK_EN
    assign tlast_mismatch  = data_hs && (up_data_tlast != data_out_tlast);
`else
    logic up_tlast_unused;
    assign up_tlast_unused = up_data_tlast;
    assign tlast_mismatch  = 1'b0;
`endif

    logic inputs_done, outputs_done;

    always_comb begin
        state_d      = state_q;
        n_symb_d     = n_symb_q;
        re_per_sym_d = re_per_sym_q;
        total_d      = total_q;
        dmrs_cnt_d   = dmrs_cnt_q + {11'd0, dmrs_hs};
        data_cnt_d   = data_cnt_q + {11'd0, data_hs};
        sym_re_cnt_d = sym_re_cnt_q;
        out_cnt_d    = out_cnt_q;
        err_d        = err_q | tlast_mismatch;

        if (data_hs) begin
            sym_re_cnt_d = data_out_tlast ? 10'd0 : (sym_re_cnt_q + 10'd1);
        end
        // Saturate at n_symb so stray extra tlasts cannot wrap the count.
        if (estm_last_hs && (out_cnt_q != n_symb_q)) begin
            out_cnt_d = out_cnt_q + 2'd1;
        end

        // Use next-cycle counts so the cycle carrying the last beat / last
        // estimate already counts towards completion.
        inputs_done  = (dmrs_cnt_d == total_q) && (data_cnt_d == total_q);
        outputs_done = (out_cnt_d == n_symb_q);

        case (state_q)
            S_IDLE: begin
                if (cfg_in_tvalid) begin
                    if (cfg_ok) begin
                        state_d      = S_RUN;
                        n_symb_d     = cfg_n_symb;
                        re_per_sym_d = cfg_re;
                        total_d      = cfg_total;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (inputs_done) begin
                    state_d = outputs_done ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (outputs_done) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d      = S_IDLE;
                n_symb_d     = 2'd0;
                re_per_sym_d = 10'd0;
                total_d      = 12'd0;
                dmrs_cnt_d   = 12'd0;
                data_cnt_d   = 12'd0;
                sym_re_cnt_d = 10'd0;
                out_cnt_d    = 2'd0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            n_symb_q     <= 2'd0;
            re_per_sym_q <= 10'd0;
            total_q      <= 12'd0;
            dmrs_cnt_q   <= 12'd0;
            data_cnt_q   <= 12'd0;
            sym_re_cnt_q <= 10'd0;
            out_cnt_q    <= 2'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_symb_q     <= n_symb_d;
            re_per_sym_q <= re_per_sym_d;
            total_q      <= total_d;
            dmrs_cnt_q   <= dmrs_cnt_d;
            data_cnt_q   <= data_cnt_d;
            sym_re_cnt_q <= sym_re_cnt_d;
            out_cnt_q    <= out_cnt_d;
            err_q        <= err_d;
        end
    end

    assign cfg_in_tready = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign err           = err_q;

endmodule

// File: tb/tb_wn_pdcchrx_modrem_ctrl.sv
// Purpose : randomized self-checking bench for wn_pdcchrx_modrem_ctrl against a job-level reference model.
// Latency : model predicts zero-latency forwarding, 1-cycle cfg->RUN and 1-cycle completion->done.
// Backpress: random upstream valid stalls and random engine ready stalls.
module tb_wn_pdcchrx_modrem_ctrl;

    localparam int NRX = 2;
    localparam int DW  = NRX * 32;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [15:0]   cfg_in_tdata = '0;
    logic          cfg_in_tvalid = 1'b0;
    logic          cfg_in_tready;
    logic [7:0]    up_dmrs_tdata = '0;
    logic          up_dmrs_tvalid = 1'b0;
    logic          up_dmrs_tready;
    logic [DW-1:0] up_data_tdata = '0;
    logic          up_data_tvalid = 1'b0;
    logic          up_data_tlast = 1'b0;
    logic          up_data_tready;
    logic [7:0]    dmrs_out_tdata;
    logic          dmrs_out_tvalid;
    logic          dmrs_out_tready = 1'b0;
    logic [DW-1:0] data_out_tdata;
    logic          data_out_tvalid;
    logic          data_out_tlast;
    logic          data_out_tready = 1'b0;
    logic          estm_tvalid = 1'b0;
    logic          estm_tready = 1'b0;
    logic          estm_tlast = 1'b0;
    logic          busy, done, err;

    always #5 clk = ~clk;

    wn_pdcchrx_modrem_ctrl #(.nRX(NRX), .MAX_RB(275)) dut (
        .clk(clk), .rstn(rstn),
        .cfg_in_tdata(cfg_in_tdata), .cfg_in_tvalid(cfg_in_tvalid), .cfg_in_tready(cfg_in_tready),
        .up_dmrs_tdata(up_dmrs_tdata), .up_dmrs_tvalid(up_dmrs_tvalid), .up_dmrs_tready(up_dmrs_tready),
        .up_data_tdata(up_data_tdata), .up_data_tvalid(up_data_tvalid), .up_data_tlast(up_data_tlast),
        .up_data_tready(up_data_tready),
        .dmrs_out_tdata(dmrs_out_tdata), .dmrs_out_tvalid(dmrs_out_tvalid), .dmrs_out_tready(dmrs_out_tready),
        .data_out_tdata(data_out_tdata), .data_out_tvalid(data_out_tvalid), .data_out_tlast(data_out_tlast),
        .data_out_tready(data_out_tready),
        .estm_tvalid(estm_tvalid), .estm_tready(estm_tready), .estm_tlast(estm_tlast),
        .busy(busy), .done(done), .err(err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: a job is a count of beats per stream plus a count of
    // estimate tlasts; done follows one cycle after all three are complete.
    int m_job = 0, m_done_pulse = 0, m_err = 0;
    int m_nsymb = 0, m_re = 0, m_total = 0;
    int m_dmrs = 0, m_data = 0, m_est = 0;

    // Stimulus state
    int job_id = 0, stall_g = 0, corrupt_g = 0;
    int cfg_pending = 0, cfg_taken = 0;
    logic [15:0] cfg_word = '0;
    int src_d = 0, src_a = 0, wait_d = 0, wait_a = 0;
    int prev_acc_d = 0, prev_acc_a = 0;

    // DUT-side observations, pinned against literals after each directed job
    int obs_d = 0, obs_a = 0, obs_done = 0;
    int obs_tl[$];

    function automatic logic [7:0] dword(input int i);
        return 8'(i * 7 + 3);
    endfunction

    function automatic logic [DW-1:0] aword(input int i);
        return {32'(job_id), 32'(i)};
    endfunction

    task automatic tick();
        int eb, edr, eda, etl, ad, aa, np, nrb, ns;
        @(negedge clk);
        cfg_in_tvalid = (cfg_pending != 0);
        cfg_in_tdata  = cfg_word;

        if (prev_acc_d != 0) begin src_d++; wait_d = $urandom_range(0, stall_g); end
        else if (wait_d > 0) wait_d--;
        up_dmrs_tvalid = (wait_d == 0);
        up_dmrs_tdata  = dword(src_d);

        if (prev_acc_a != 0) begin src_a++; wait_a = $urandom_range(0, stall_g); end
        else if (wait_a > 0) wait_a--;
        up_data_tvalid = (wait_a == 0);
        up_data_tdata  = aword(src_a);
        up_data_tlast  = (m_re > 0) && (((src_a + 1) % m_re) == 0);
        if (corrupt_g == src_a + 1) up_data_tlast = ~up_data_tlast;

        dmrs_out_tready = (stall_g == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        data_out_tready = (stall_g == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);

        if ((m_job != 0) && (m_est < m_data / m_re) && ((stall_g == 0) || ($urandom_range(0, 1) != 0))) begin
            estm_tvalid = 1'b1; estm_tready = 1'b1; estm_tlast = 1'b1;
        end else begin
            estm_tvalid = 1'($urandom_range(0, 1));
            estm_tready = (stall_g == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            estm_tlast  = estm_tvalid && !estm_tready && ($urandom_range(0, 1) != 0);
        end

        #1;
        eb  = ((m_job != 0) || (m_done_pulse != 0)) ? 1 : 0;
        edr = ((m_job != 0) && (m_dmrs < m_total)) ? 1 : 0;
        eda = ((m_job != 0) && (m_data < m_total)) ? 1 : 0;
        etl = ((eda != 0) && (((m_data + 1) % m_re) == 0)) ? 1 : 0;

        chk("cfg_in_tready", cfg_in_tready, (eb == 0));
        chk("busy", busy, (eb != 0));
        chk("done", done, (m_done_pulse != 0));
        chk("err", err, (m_err != 0));
        chk("up_dmrs_tready", up_dmrs_tready, (edr != 0) && dmrs_out_tready);
        chk("dmrs_out_tvalid", dmrs_out_tvalid, (edr != 0) && up_dmrs_tvalid);
        chk("up_data_tready", up_data_tready, (eda != 0) && data_out_tready);
        chk("data_out_tvalid", data_out_tvalid, (eda != 0) && up_data_tvalid);
        chk("data_out_tlast", data_out_tlast, (etl != 0));

        ad = ((edr != 0) && up_dmrs_tvalid && dmrs_out_tready) ? 1 : 0;
        aa = ((eda != 0) && up_data_tvalid && data_out_tready) ? 1 : 0;
        if (ad != 0) chk("dmrs_word", dmrs_out_tdata, dword(m_dmrs));
        if (aa != 0) chk("data_word", data_out_tdata, aword(m_data));

        if (dmrs_out_tvalid && dmrs_out_tready) obs_d++;
        if (data_out_tvalid && data_out_tready) begin
            obs_a++;
            if (data_out_tlast) obs_tl.push_back(obs_a);
        end
        if (done) obs_done++;

        // Model advance for the coming clock edge
        if (ad != 0) m_dmrs++;
        if (aa != 0) begin
`ifdef WN_PDCCHRX_MODREM_CTRL_ERRCHK_EN
            if (up_data_tlast != (etl != 0)) m_err = 1;
`endif
            m_data++;
        end
        if ((m_job != 0) && estm_tvalid && estm_tready && estm_tlast) m_est++;
        np = 0;
        if ((m_job != 0) && (m_dmrs == m_total) && (m_data == m_total) && (m_est >= m_nsymb)) begin
            m_job = 0;
            np = 1;
        end
        cfg_taken = 0;
        if ((eb == 0) && cfg_in_tvalid) begin
            cfg_taken = 1;
            nrb = int'(cfg_in_tdata[8:0]);
            ns  = int'(cfg_in_tdata[10:9]);
            if ((nrb >= 1) && (nrb <= 275) && (ns != 0)) begin
                m_job = 1; m_nsymb = ns; m_re = 3 * nrb; m_total = 3 * nrb * ns;
                m_dmrs = 0; m_data = 0; m_est = 0; src_d = 0; src_a = 0;
            end else begin
                m_err = 1;
            end
        end
        m_done_pulse = np;
        prev_acc_d = ad;
        prev_acc_a = aa;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cfg_in_tready"}, cfg_in_tready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_dmrs_out_tvalid"}, dmrs_out_tvalid, 0);
        chk({tag, "_data_out_tvalid"}, data_out_tvalid, 0);
        chk({tag, "_data_out_tlast"}, data_out_tlast, 0);
        chk({tag, "_up_dmrs_tready"}, up_dmrs_tready, 0);
        chk({tag, "_up_data_tready"}, up_data_tready, 0);
    endtask

    task automatic clear_obs();
        obs_d = 0; obs_a = 0; obs_done = 0;
        obs_tl.delete();
    endtask

    task automatic run_job(input int nrb, input int nsymb, input int stall,
                           input int corrupt, input int abort_at);
        int finished;
        finished = 0;
        job_id++;
        clear_obs();
        stall_g   = stall;
        corrupt_g = corrupt;
        cfg_word  = {5'd0, 2'(nsymb), 9'(nrb)};
        cfg_pending = 1;
        for (int c = 0; c < 40000; c++) begin
            tick();
            if (cfg_taken != 0) cfg_pending = 0;
            if ((abort_at > 0) && (m_job != 0) && (m_data == abort_at)) begin
                #2 rstn = 1'b0;
                #1 chk_reset_vals("abort");
                m_job = 0; m_done_pulse = 0; m_err = 0;
                prev_acc_d = 0; prev_acc_a = 0; cfg_pending = 0;
                @(posedge clk);
                #2 rstn = 1'b1;
                finished = 1;
                break;
            end
            if (m_done_pulse != 0) begin
                tick();
                finished = 1;
                break;
            end
        end
        if (finished == 0) chk("job_timeout", 0, 1);
        corrupt_g = 0;
        // Idle cycles with upstream still offering surplus beats
        for (int i = 0; i < 12; i++) tick();
    endtask

    task automatic send_cfg(input int nrb, input int nsymb);
        int taken;
        taken = 0;
        cfg_word = {5'd0, 2'(nsymb), 9'(nrb)};
        cfg_pending = 1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (cfg_taken != 0) begin cfg_pending = 0; taken = 1; break; end
        end
        if (taken == 0) chk("cfg_timeout", 0, 1);
        for (int i = 0; i < 4; i++) tick();
    endtask

    initial begin
        #2 chk_reset_vals("reset");
        @(posedge clk);
        #2 rstn = 1'b1;
        for (int i = 0; i < 3; i++) tick();

        // Small job at full throughput
        run_job(2, 1, 0, 0, 0);
        chk("j1_dmrs_beats", obs_d, 6);
        chk("j1_data_beats", obs_a, 6);
        chk("j1_tlast_count", obs_tl.size(), 1);
        if (obs_tl.size() == 1) chk("j1_tlast_pos", obs_tl[0], 6);
        chk("j1_done_count", obs_done, 1);
        chk("j1_err", err, 0);

        // Largest job under random stalls
        run_job(275, 3, 9, 0, 0);
        chk("j2_dmrs_beats", obs_d, 2475);
        chk("j2_data_beats", obs_a, 2475);
        chk("j2_tlast_count", obs_tl.size(), 3);
        if (obs_tl.size() == 3) begin
            chk("j2_tlast_pos0", obs_tl[0], 825);
            chk("j2_tlast_pos1", obs_tl[1], 1650);
            chk("j2_tlast_pos2", obs_tl[2], 2475);
        end
        chk("j2_done_count", obs_done, 1);

        // Illegal configs are consumed and flag err
        job_id++;
        clear_obs();
        stall_g = 0;
        send_cfg(0, 1);
        chk("ill0_err", err, 1);
        chk("ill0_busy", busy, 0);
        send_cfg(276, 1);
        send_cfg(5, 0);
        chk("ill_err", err, 1);
        chk("ill_busy", busy, 0);
        chk("ill_cfg_in_tready", cfg_in_tready, 1);
        chk("ill_dmrs_beats", obs_d, 0);
        chk("ill_data_beats", obs_a, 0);

        // Reset in the middle of a job, then a clean job
        run_job(2, 1, 0, 0, 3);
        chk("abort_data_beats", obs_a, 3);
        chk("abort_err_cleared", err, 0);
        run_job(2, 1, 0, 0, 0);
        chk("j3_data_beats", obs_a, 6);
        chk("j3_done_count", obs_done, 1);
        chk("j3_err", err, 0);

        // Wrong upstream tlast on beat 3
        run_job(2, 1, 0, 3, 0);
        chk("j4_tlast_count", obs_tl.size(), 1);
        if (obs_tl.size() == 1) chk("j4_tlast_pos", obs_tl[0], 6);
`ifdef WN_PDCCHRX_MODREM_CTRL_ERRCHK_EN
        chk("j4_err", err, 1);
`else
        chk("j4_err", err, 0);
`endif

        // Random jobs
        for (int j = 0; j < 6; j++) begin
            int nrb, ns;
            nrb = $urandom_range(1, 30);
            ns  = $urandom_range(1, 3);
            run_job(nrb, ns, $urandom_range(0, 9), 0, 0);
            chk("rnd_data_beats", obs_a, 3 * nrb * ns);
            chk("rnd_done_count", obs_done, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wn_pdcchrx_modrem_ctrl.md
# wn_pdcchrx_modrem_ctrl

Job sequencer in front of `wn_pdcchrx_modulationremoval` in the PDCCH receive chain. Per configured CORESET allocation (RB count, symbol count) it gates the upstream DMRS-sequence and DMRS-RE data streams into the modulation-removal engine. It regenerates per-symbol `tlast` from RE counts and tracks engine output completion. It signals done once all estimates for the job have left the engine.

## Interface
Parameters:
- `nRX`, 2, receive antennas; data word width is nRX*32
- `MAX_RB`, 275, largest legal RB count

Ports:
- `clk`  in  1  clock
- `rstn`  in  1  reset; one clock; reset is asynchronous and active-low
- `cfg_in_tdata`  in  16  [8:0] n_rb, [10:9] n_symb (1..3), [15:11] reserved
- `cfg_in_tvalid`  in  1 / `cfg_in_tready`  out  1  config handshake
- `up_dmrs_tdata`  in  8 / `up_dmrs_tvalid`  in  1 / `up_dmrs_tready`  out  1  DMRS word, one per DMRS RE
- `up_data_tdata`  in  nRX*32 / `up_data_tvalid`  in / `up_data_tlast`  in / `up_data_tready`  out  received DMRS REs
- `dmrs_out_tdata`  out  8 / `dmrs_out_tvalid`  out / `dmrs_out_tready`  in  to engine dmrs_in
- `data_out_tdata`  out  nRX*32 / `data_out_tvalid`  out / `data_out_tlast`  out / `data_out_tready`  in  to engine data_in
- `estm_tvalid`, `estm_tready`, `estm_tlast`  in  1 each  snoop of the engine estm_out handshake
- `busy`  out  1  job in progress
- `done`  out  1  one-cycle pulse at job end
- `err`  out  1  sticky error; cleared only by reset

## Operation
- Derived values, latched at config accept:
  - re_per_sym = 3*n_rb (10 bit, ≤825)
  - total = re_per_sym*n_symb (12 bit)
- States:
  - IDLE: `cfg_in_tready`=1. On cfg handshake, go to RUN if 1≤n_rb≤MAX_RB and n_symb≠0. Otherwise set `err`, stay IDLE, and consume the word.
  - RUN: stream forwarding is combinational, with zero latency:
    - `dmrs_out_tvalid`=`up_dmrs_tvalid`&&(dmrs_cnt<total); `up_dmrs_tready`=`dmrs_out_tready`&&(dmrs_cnt<total).
    - The data path follows the same rule with data_cnt.
    - `data_out_tlast`=1 when sym_re_cnt==re_per_sym-1.
    - Counters increment on the respective out handshake. sym_re_cnt wraps to 0 after re_per_sym-1.
    - Go to DRAIN when both counters reach total, including the cycle the last beat is taken.
  - DRAIN: upstream readies are 0.
  - Across RUN and DRAIN: out_cnt increments on estm_tvalid&&estm_tready&&estm_tlast. When out_cnt reaches n_symb, go to DONE.
  - DONE: `done`=1 for one cycle, then go to IDLE; all counters clear.
- `busy`=1 in RUN, DRAIN and DONE.
- Simultaneous events: the last input beat and an estimate tlast in the same cycle are both counted.
- If the final estimate tlast lands while still in RUN, the block goes to DONE directly once inputs are complete.
- Outside RUN, all out tvalid=0 and upstream tready=0. Data is never dropped while tvalid is held.
- Reset mid-job: the block returns to IDLE immediately and the partial job is abandoned. The engine shares `rstn`.

## Timing
- Reset values: `cfg_in_tready`=1, `busy`=0, `done`=0, `err`=0, all out tvalid/tlast=0, upstream readies=0.
- Config handshake to first possible forwarded beat: 1 cycle, because the state is registered.
- Last estimate tlast handshake (in DRAIN) to `done` pulse: 1 cycle. `done` to `cfg_in_tready`=1: 1 cycle.
- Throughput: 1 beat/cycle per stream. DMRS and data streams advance independently.
- AXI-Stream rules: tdata/tlast are stable while tvalid is asserted. tvalid never depends on tready of the same interface.

## Configuration
- `WN_PDCCHRX_MODREM_CTRL_ERRCHK_EN` defined:
  - On each data handshake in RUN, `up_data_tlast` is compared with the generated `data_out_tlast`.
  - A mismatch sets `err`. Forwarding continues, using the generated tlast.
- Macro undefined: `up_data_tlast` is ignored and `err` is set only by illegal config.

## Test plan
- n_rb=2, n_symb=1, full throughput, estm tlast after 6 beats → 6 beats forwarded, `data_out_tlast` on beat 6, `done` 1 cycle after estm tlast, `err`=0.
- n_rb=275, n_symb=3, random 0–9 cycle stalls on all streams → 2475 beats per stream, tlast on beats 825/1650/2475, exactly one `done`.
- cfg n_rb=0, then n_rb=276 → `err`=1, state stays IDLE, `busy`=0, no beats accepted.
- Upstream sends 10 extra beats beyond total → extras not accepted (`up_*_tready`=0 after the 6th beat for n_rb=2, n_symb=1).
- `rstn` low after 3 of 6 beats → all outputs return to reset values asynchronously; next job runs cleanly.
- ERRCHK_EN build, `up_data_tlast` asserted on beat 3 of 6 → `err`=1, `data_out_tlast` still only on beat 6.
